// File: rtl/mem_arbiter.sv
// Memory arbiter for the icache and dcache. It has two read request queues and a
// dcache write-back buffer, issues one memory op per cycle, and routes in-order read data back to the requesting port.
module mem_arbiter #(
    parameter int WORD_SIZE = 32,
    parameter int LINE_SIZE = 128,
    parameter int LATENCY   = 5,
    parameter int QDEPTH    = 2,
    parameter int WDEPTH    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_req,
    input  logic [WORD_SIZE-1:0] i_addr,
    output logic                 i_full,
    output logic                 i_res,
    output logic [WORD_SIZE-1:0] i_res_addr,
    output logic [LINE_SIZE-1:0] i_res_data,
    input  logic                 d_req,
    input  logic [WORD_SIZE-1:0] d_addr,
    output logic                 d_full,
    output logic                 d_res,
    output logic [WORD_SIZE-1:0] d_res_addr,
    output logic [LINE_SIZE-1:0] d_res_data,
    input  logic                 d_wr,
    input  logic [WORD_SIZE-1:0] d_wr_addr,
    input  logic [LINE_SIZE-1:0] d_wr_data,
    output logic                 m_req,
    output logic                 m_we,
    output logic [WORD_SIZE-1:0] m_addr,
    output logic [LINE_SIZE-1:0] m_wdata,
    input  logic                 m_res,
    input  logic [LINE_SIZE-1:0] m_res_data,
    output logic                 ovf
);

    localparam int QCW = $clog2(QDEPTH + 1);
    localparam int WCW = $clog2(WDEPTH + 1);
    localparam int WEW = WORD_SIZE + LINE_SIZE;
    localparam logic [WORD_SIZE-1:0] LINE_MASK = ~WORD_SIZE'(15);

    // Read queues are indexed by port: 0 = icache, 1 = dcache. Entry 0 is the head.
    logic [QDEPTH-1:0][WORD_SIZE-1:0] rq_mem     [2];
    logic [QDEPTH-1:0][WORD_SIZE-1:0] rq_shifted [2];
    logic [QCW-1:0]                   rq_count   [2];
    logic [QCW-1:0]                   rq_wr_idx  [2];
    logic [WORD_SIZE-1:0]             rq_din     [2];
    logic [WORD_SIZE-1:0]             rq_head    [2];
    logic [1:0] rq_req, rq_full, rq_valid, rq_push, rq_pop;

    // The write buffer keeps {data, addr}.
    logic [WDEPTH-1:0][WEW-1:0] wq_mem;
    logic [WDEPTH-1:0][WEW-1:0] wq_shifted;
    logic [WCW-1:0]             wq_count;
    logic [WCW-1:0]             wq_wr_idx;
    logic [WORD_SIZE-1:0]       wq_head_addr;
    logic [LINE_SIZE-1:0]       wq_head_data;
    logic                       wq_full, wq_valid, wq_push, wq_pop;

    logic rr_dport;
    logic raw_hazard;
    logic grant_w, grant_i, grant_d;

    logic                 trk_valid [1:LATENCY];
    logic                 trk_dport [1:LATENCY];
    logic [WORD_SIZE-1:0] trk_addr  [1:LATENCY];
    logic                 resp_hit;

    assign rq_req    = {d_req, i_req};
    assign rq_din[0] = i_addr & LINE_MASK;
    assign rq_din[1] = d_addr & LINE_MASK;
    assign rq_pop    = {grant_d, grant_i};

    // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rq_full[p]    = (rq_count[p] == QCW'(QDEPTH));
            rq_valid[p]   = (rq_count[p] != '0);
            rq_head[p]    = rq_mem[p][0];
            rq_push[p]    = rq_req[p] && !rq_full[p];
            rq_shifted[p] = rq_mem[p] >> WORD_SIZE;
            rq_wr_idx[p]  = rq_pop[p] ? rq_count[p] - QCW'(1) : rq_count[p];
        end
    end

    assign wq_full      = (wq_count == WCW'(WDEPTH));
    assign wq_valid     = (wq_count != '0);
    assign wq_push      = d_wr && !wq_full;
    assign wq_pop       = grant_w;
    assign wq_head_addr = wq_mem[0][WORD_SIZE-1:0];
    assign wq_head_data = wq_mem[0][WEW-1:WORD_SIZE];
    assign wq_shifted   = wq_mem >> WEW;
    assign wq_wr_idx    = wq_pop ? wq_count - WCW'(1) : wq_count;

    // NOTE: queue storage has no reset. Only the counts say which entries are valid, so the data needs no clearing.
    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < QDEPTH; k++) begin
                if (rq_push[p] && k == int'(rq_wr_idx[p])) rq_mem[p][k] <= rq_din[p];
                else if (rq_pop[p])                        rq_mem[p][k] <= rq_shifted[p][k];
            end
        end
        for (int k = 0; k < WDEPTH; k++) begin
            if (wq_push && k == int'(wq_wr_idx)) wq_mem[k] <= {d_wr_data, d_wr_addr & LINE_MASK};
            else if (wq_pop)                     wq_mem[k] <= wq_shifted[k];
        end
    end

    // NOTE: sequential state uses non-blocking assignments, so every register samples the values from before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rq_count[0] <= '0;
            rq_count[1] <= '0;
            wq_count    <= '0;
            rr_dport    <= 1'b0;
            ovf         <= 1'b0;
        end else begin
            for (int p = 0; p < 2; p++)
                rq_count[p] <= rq_count[p] + QCW'(rq_push[p]) - QCW'(rq_pop[p]);
            wq_count <= wq_count + WCW'(wq_push) - WCW'(wq_pop);
            if (grant_i)      rr_dport <= 1'b1;
            else if (grant_d) rr_dport <= 1'b0;
            if (|(rq_req & rq_full) || (d_wr && wq_full)) ovf <= 1'b1;
        end
    end

    // A read must not pass a buffered write to the same line.
    always_comb begin
        raw_hazard = 1'b0;
        for (int k = 0; k < WDEPTH; k++) begin
            if (k < int'(wq_count)) begin
                for (int p = 0; p < 2; p++)
                    if (rq_valid[p] && wq_mem[k][WORD_SIZE-1:0] == rq_head[p]) raw_hazard = 1'b1;
            end
        end
    end

    always_comb begin
        grant_w = 1'b0;
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (wq_valid && (wq_full || raw_hazard))       grant_w = 1'b1;
        else if (rq_valid[0] && (!rq_valid[1] || !rr_dport)) grant_i = 1'b1;
        else if (rq_valid[1])                          grant_d = 1'b1;
        else if (wq_valid)                             grant_w = 1'b1;
    end

    assign m_req   = grant_w || grant_i || grant_d;
    assign m_we    = grant_w;
    assign m_wdata = grant_w ? wq_head_data : '0;

    always_comb begin
        m_addr = '0;
        if (grant_w)      m_addr = wq_head_addr;
        else if (grant_i) m_addr = rq_head[0];
        else if (grant_d) m_addr = rq_head[1];
    end

    assign i_full = rq_full[0];
    assign d_full = rq_full[1];

    // Memory answers in order after LATENCY cycles, so slot k holds the op issued k cycles ago.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 1; k <= LATENCY; k++) begin
                trk_valid[k] <= 1'b0;
                trk_dport[k] <= 1'b0;
                trk_addr[k]  <= '0;
            end
        end else begin
            trk_valid[1] <= grant_i || grant_d;
            trk_dport[1] <= grant_d;
            trk_addr[1]  <= m_addr;
            for (int k = 2; k <= LATENCY; k++) begin
                trk_valid[k] <= trk_valid[k-1];
                trk_dport[k] <= trk_dport[k-1];
                trk_addr[k]  <= trk_addr[k-1];
            end
        end
    end

    assign resp_hit   = m_res && trk_valid[LATENCY];
    assign i_res      = resp_hit && !trk_dport[LATENCY];
    assign d_res      = resp_hit && trk_dport[LATENCY];
    assign i_res_addr = i_res ? trk_addr[LATENCY] : '0;
    assign d_res_addr = d_res ? trk_addr[LATENCY] : '0;
    assign i_res_data = i_res ? m_res_data : '0;
    assign d_res_data = d_res ? m_res_data : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter. It runs table-driven directed vectors, short hand-written
// sequences for overflow and reset, and random traffic checked against a queue-based model.
module tb_mem_arbiter;

    localparam int WS = 32, LS = 128, LAT = 5, QD = 2, WD = 2;
    localparam bit Y = 1'b1, N = 1'b0;
    localparam logic [31:0]  Z     = 32'h0;
    localparam logic [127:0] MDATA = 128'hA5A5_0001_B6B6_0002_C7C7_0003_D8D8_0004;
    localparam logic [127:0] WDATA = 128'h1111_2222_3333_4444_5555_6666_7777_8888;

    logic clk = 1'b0;
    logic rst;
    logic i_req, d_req, d_wr, m_res;
    logic [WS-1:0] i_addr, d_addr, d_wr_addr;
    logic [LS-1:0] d_wr_data, m_res_data;
    logic i_full, i_res, d_full, d_res, m_req, m_we, ovf;
    logic [WS-1:0] i_res_addr, d_res_addr, m_addr;
    logic [LS-1:0] i_res_data, d_res_data, m_wdata;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.WORD_SIZE(WS), .LINE_SIZE(LS), .LATENCY(LAT), .QDEPTH(QD), .WDEPTH(WD)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_full(i_full), .i_res(i_res),
        .i_res_addr(i_res_addr), .i_res_data(i_res_data),
        .d_req(d_req), .d_addr(d_addr), .d_full(d_full), .d_res(d_res),
        .d_res_addr(d_res_addr), .d_res_data(d_res_data),
        .d_wr(d_wr), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_res(m_res), .m_res_data(m_res_data), .ovf(ovf)
    );

    typedef struct {
        logic m_req, m_we;
        logic [31:0] m_addr;
        logic [127:0] m_wdata;
        logic i_res, d_res;
        logic [31:0] i_res_addr, d_res_addr;
        logic [127:0] i_res_data, d_res_data;
        logic i_full, d_full, ovf;
    } exp_t;

    typedef struct {
        bit rst, chk, i_req;
        logic [31:0] i_addr;
        bit d_req;
        logic [31:0] d_addr;
        bit d_wr;
        logic [31:0] wa;
        bit m_res, e_req, e_we;
        logic [31:0] e_addr;
        bit e_ires, e_dres;
        logic [31:0] e_raddr;
    } vec_t;

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h, want %h", name, $time, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input exp_t e);
        check({tag, ".m_op"}, 192'({m_req, m_we, m_addr}), 192'({e.m_req, e.m_we, e.m_addr}));
        check({tag, ".m_wdata"}, 192'(m_wdata), 192'(e.m_wdata));
        check({tag, ".i_resp"}, 192'({i_res, i_res_addr, i_res_data}),
              192'({e.i_res, e.i_res_addr, e.i_res_data}));
        check({tag, ".d_resp"}, 192'({d_res, d_res_addr, d_res_data}),
              192'({e.d_res, e.d_res_addr, e.d_res_data}));
        check({tag, ".flags"}, 192'({i_full, d_full, ovf}), 192'({e.i_full, e.d_full, e.ovf}));
    endtask

    task automatic clear_inputs();
        i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_addr = '0;
        d_wr = 1'b0; d_wr_addr = '0; d_wr_data = '0; m_res = 1'b0; m_res_data = '0;
    endtask

    // Returns at a falling edge with rst low. The caller then drives the next cycle.
    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic vec_t v(input bit rs, ck, ir, input logic [31:0] ia, input bit dr,
                               input logic [31:0] da, input bit dw, input logic [31:0] wa,
                               input bit mr, er, ew, input logic [31:0] ea,
                               input bit eir, edr, input logic [31:0] era);
        vec_t r;
        r = '{rs, ck, ir, ia, dr, da, dw, wa, mr, er, ew, ea, eir, edr, era};
        return r;
    endfunction

    function automatic vec_t idle(input bit mr);
        return v(N, Y, N, Z, N, Z, N, Z, mr, N, N, Z, N, N, Z);
    endfunction

    // ---------------- behavioural model ----------------
    typedef struct { int due; bit dport; logic [31:0] addr; } pend_t;
    logic [31:0]  iq[$], dq[$], wqa[$];
    logic [127:0] wqd[$];
    pend_t        pend[$];
    int           rr_next;   // 0: icache gets the next read slot, 1: dcache
    bit           m_ovf;
    int           cyc;

    task automatic model_clear();
        iq.delete(); dq.delete(); wqa.delete(); wqd.delete(); pend.delete();
        rr_next = 0; m_ovf = 1'b0;
    endtask

    // g: 0 = idle, 1 = write, 2 = icache read, 3 = dcache read
    task automatic model_predict(output exp_t e, output int g);
        bit raw;
        int p;
        int sz [2];
        e = '{default: '0};
        raw = 1'b0;
        foreach (wqa[k])
            if ((iq.size() > 0 && wqa[k] == iq[0]) || (dq.size() > 0 && wqa[k] == dq[0])) raw = 1'b1;
        sz[0] = iq.size();
        sz[1] = dq.size();
        g = 0;
        if (wqa.size() > 0 && (wqa.size() == WD || raw)) g = 1;
        else begin
            p = rr_next;
            if (sz[p] == 0) p = 1 - p;
            if (sz[p] > 0)            g = 2 + p;
            else if (wqa.size() > 0)  g = 1;
        end
        case (g)
            1: begin e.m_req = 1'b1; e.m_we = 1'b1; e.m_addr = wqa[0]; e.m_wdata = wqd[0]; end
            2: begin e.m_req = 1'b1; e.m_addr = iq[0]; end
            3: begin e.m_req = 1'b1; e.m_addr = dq[0]; end
            default: ;
        endcase
        foreach (pend[k]) begin
            if (pend[k].due == cyc && m_res) begin
                if (pend[k].dport) begin
                    e.d_res = 1'b1; e.d_res_addr = pend[k].addr; e.d_res_data = m_res_data;
                end else begin
                    e.i_res = 1'b1; e.i_res_addr = pend[k].addr; e.i_res_data = m_res_data;
                end
            end
        end
        e.i_full = (iq.size() == QD);
        e.d_full = (dq.size() == QD);
        e.ovf    = m_ovf;
    endtask

    task automatic model_update(input int g);
        bit ia, da, wa;
        if (rst) model_clear();
        else begin
            ia = i_req && iq.size() < QD;
            da = d_req && dq.size() < QD;
            wa = d_wr && wqa.size() < WD;
            if ((i_req && !ia) || (d_req && !da) || (d_wr && !wa)) m_ovf = 1'b1;
            case (g)
                1: begin void'(wqa.pop_front()); void'(wqd.pop_front()); end
                2: begin pend.push_back('{cyc + LAT, 1'b0, iq[0]}); void'(iq.pop_front()); rr_next = 1; end
                3: begin pend.push_back('{cyc + LAT, 1'b1, dq[0]}); void'(dq.pop_front()); rr_next = 0; end
                default: ;
            endcase
            if (ia) iq.push_back(i_addr & ~32'hF);
            if (da) dq.push_back(d_addr & ~32'hF);
            if (wa) begin wqa.push_back(d_wr_addr & ~32'hF); wqd.push_back(d_wr_data); end
            while (pend.size() > 0 && pend[0].due <= cyc) void'(pend.pop_front());
        end
        cyc++;
    endtask

    function automatic logic [31:0] rand_addr();
        return 32'h1000 + 32'($urandom_range(0, 3)) * 32'h10 + 32'($urandom_range(0, 15));
    endfunction

    initial begin
        vec_t vecs[$];
        exp_t e;
        int   g;

        rst = 1'b1;
        clear_inputs();
        do_reset();

        #1;
        check_outs("post_reset", '{default: '0});

        // Single read, a response ignored on an empty slot, contention, then RAW.
        vecs.push_back(v(N, Y, Y, 32'h1234, N, Z, N, Z, N, N, N, Z, N, N, Z));
        vecs.push_back(v(N, Y, N, Z, N, Z, N, Z, N, Y, N, 32'h1230, N, N, Z));
        vecs.push_back(idle(N));
        vecs.push_back(idle(Y));
        vecs.push_back(idle(N));
        vecs.push_back(idle(N));
        vecs.push_back(v(N, Y, N, Z, N, Z, N, Z, Y, N, N, Z, Y, N, 32'h1230));
        vecs.push_back(v(Y, N, N, Z, N, Z, N, Z, N, N, N, Z, N, N, Z));
        vecs.push_back(v(N, Y, Y, 32'h100, Y, 32'h208, N, Z, N, N, N, Z, N, N, Z));
        vecs.push_back(v(N, Y, N, Z, N, Z, N, Z, N, Y, N, 32'h100, N, N, Z));
        vecs.push_back(v(N, Y, N, Z, N, Z, N, Z, N, Y, N, 32'h200, N, N, Z));
        vecs.push_back(idle(N));
        vecs.push_back(idle(N));
        vecs.push_back(idle(N));
        vecs.push_back(v(N, Y, N, Z, N, Z, N, Z, Y, N, N, Z, Y, N, 32'h100));
        vecs.push_back(v(N, Y, N, Z, N, Z, N, Z, Y, N, N, Z, N, Y, 32'h200));
        vecs.push_back(v(N, Y, N, Z, Y, 32'h40, Y, 32'h40, N, N, N, Z, N, N, Z));
        vecs.push_back(v(N, Y, N, Z, N, Z, N, Z, N, Y, Y, 32'h40, N, N, Z));
        vecs.push_back(v(N, Y, N, Z, N, Z, N, Z, N, Y, N, 32'h40, N, N, Z));
        vecs.push_back(idle(N));
        vecs.push_back(idle(N));
        vecs.push_back(idle(N));
        vecs.push_back(idle(N));
        vecs.push_back(v(N, Y, N, Z, N, Z, N, Z, Y, N, N, Z, N, Y, 32'h40));

        foreach (vecs[r]) begin
            rst = vecs[r].rst;
            i_req = vecs[r].i_req; i_addr = vecs[r].i_addr;
            d_req = vecs[r].d_req; d_addr = vecs[r].d_addr;
            d_wr = vecs[r].d_wr; d_wr_addr = vecs[r].wa; d_wr_data = vecs[r].d_wr ? WDATA : '0;
            m_res = vecs[r].m_res; m_res_data = MDATA;
            #1;
            if (vecs[r].chk) begin
                e = '{default: '0};
                e.m_req = vecs[r].e_req; e.m_we = vecs[r].e_we; e.m_addr = vecs[r].e_addr;
                e.m_wdata = vecs[r].e_we ? WDATA : '0;
                e.i_res = vecs[r].e_ires;
                e.i_res_addr = vecs[r].e_ires ? vecs[r].e_raddr : '0;
                e.i_res_data = vecs[r].e_ires ? MDATA : '0;
                e.d_res = vecs[r].e_dres;
                e.d_res_addr = vecs[r].e_dres ? vecs[r].e_raddr : '0;
                e.d_res_data = vecs[r].e_dres ? MDATA : '0;
                check_outs($sformatf("tbl%0d", r), e);
            end
            @(negedge clk);
        end

        // Overflow: a RAW write holds back the read queue while three requests arrive.
        do_reset();
        d_wr = 1'b1; d_wr_addr = 32'h80; d_wr_data = WDATA; i_req = 1'b1; i_addr = 32'h80;
        @(negedge clk);
        clear_inputs(); i_req = 1'b1; i_addr = 32'h95;
        #1;
        check("ovf.c1_op", 192'({m_req, m_we, m_addr}), 192'({1'b1, 1'b1, 32'h80}));
        check("ovf.c1_full", 192'({i_full, ovf}), 192'({1'b0, 1'b0}));
        @(negedge clk);
        clear_inputs(); i_req = 1'b1; i_addr = 32'hA0;
        #1;
        check("ovf.c2_full", 192'({i_full, ovf}), 192'({1'b1, 1'b0}));
        check("ovf.c2_op", 192'({m_req, m_we, m_addr}), 192'({1'b1, 1'b0, 32'h80}));
        @(negedge clk);
        clear_inputs();
        #1;
        check("ovf.c3_flags", 192'({i_full, ovf}), 192'({1'b0, 1'b1}));
        check("ovf.c3_op", 192'({m_req, m_we, m_addr}), 192'({1'b1, 1'b0, 32'h90}));
        @(negedge clk);
        #1;
        check("ovf.c4_dropped", 192'({m_req, ovf}), 192'({1'b0, 1'b1}));
        @(negedge clk);

        // Reset while a read is in flight: its response must be ignored.
        do_reset();
        i_req = 1'b1; i_addr = 32'h300;
        @(negedge clk);
        clear_inputs();
        #1;
        check("rstmid.issue", 192'({m_req, m_we, m_addr}), 192'({1'b1, 1'b0, 32'h300}));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 3; c <= 8; c++) begin
            m_res = 1'b1; m_res_data = {$urandom, $urandom, $urandom, $urandom};
            #1;
            check_outs($sformatf("rstmid.c%0d", c), '{default: '0});
            @(negedge clk);
        end

        // Random traffic with occasional resets, checked against the model.
        do_reset();
        model_clear();
        cyc = 0;
        for (int t = 0; t < 3000; t++) begin
            rst        = ($urandom_range(0, 149) == 0);
            i_req      = ($urandom_range(0, 99) < 35);
            i_addr     = rand_addr();
            d_req      = ($urandom_range(0, 99) < 35);
            d_addr     = rand_addr();
            d_wr       = ($urandom_range(0, 99) < 25);
            d_wr_addr  = rand_addr();
            d_wr_data  = {$urandom, $urandom, $urandom, $urandom};
            m_res      = ($urandom_range(0, 99) < 60);
            m_res_data = {$urandom, $urandom, $urandom, $urandom};
            #1;
            model_predict(e, g);
            check_outs("rand", e);
            @(posedge clk);
            model_update(g);
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
